// File: rtl/bnoc_pkg.sv
// Shared definitions for the bidirectional-channel controller slice.
// Holds the controller state encoding, the default requester count,
// the width of the binary grant index and the round-robin pointer
// advance helper.
package bnoc_pkg;

    localparam int NUM_REQ_DEF = 10;
    localparam int SEL_W       = 4;

    typedef enum logic [1:0] {
        INPUT  = 2'd0,
        WAIT   = 2'd1,
        OUTPUT = 2'd2,
        TURN   = 2'd3
    } ctrlState_e;

    // Plain vector constants for the state register.
    localparam logic [1:0] ST_INPUT  = INPUT;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_OUTPUT = OUTPUT;
    localparam logic [1:0] ST_TURN   = TURN;

    // Pointer for the next search: one past the last winner, wrapping.
    function automatic logic [SEL_W-1:0] rrNext(input logic [SEL_W-1:0] idx,
                                                input int numReq);
        logic [SEL_W-1:0] result;
        if (int'(idx) >= numReq - 1) result = '0;
        else                         result = idx + SEL_W'(1);
        return result;
    endfunction

endpackage

// File: rtl/bichannel_ctrl_if.sv
// Channel-side bundle of one bichannel_ctrl end.
//   req          : per-requester channel request (into the controller)
//   gnt          : one-hot grant back to the requesters
//   sel          : binary index of the granted requester
//   inout_select : 1 = this end drives the shared channel
//   dir_req_out  : direction request / ownership flag to the neighbour
//   dir_req_in   : neighbour's dir_req_out
// slave  = controller view, master = requester/neighbour view.
interface bichannel_ctrl_if
    import bnoc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               inout_select;
    logic               dir_req_out;
    logic               dir_req_in;

    modport slave (
        input  req, dir_req_in,
        output gnt, sel, inout_select, dir_req_out
    );

    modport master (
        output req, dir_req_in,
        input  gnt, sel, inout_select, dir_req_out
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search.
//   req   : request vector
//   ptr   : index where the search starts (must be < NUM_REQ)
//   grant : one-hot winner, zero when no request is set
//   index : binary index of the winner, zero when no request is set
module rr_arbiter
    import bnoc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   index
);
    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Walk ptr, ptr+1, ... wrapping past NUM_REQ-1 back to 0.
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = SEL_W'(cand);
            end
        end
    end
endmodule

// File: rtl/bichannel_ctrl.sv
// One end of a bidirectional channel shared with a neighbour.
// Arbitrates the local requesters round-robin and negotiates channel
// direction with the neighbour via dir_req_out / dir_req_in.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : channel bundle (slave view), see bichannel_ctrl_if
// Parameters: NUM_REQ requesters (must match the interface),
// HIGH_PRIO = 1 wins simultaneous direction requests.
module bichannel_ctrl
    import bnoc_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int HIGH_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    bichannel_ctrl_if.slave    bus
);
    logic [1:0]         state;
    logic [SEL_W-1:0]   rrPtr;
    logic [NUM_REQ-1:0] arbGnt;
    logic [SEL_W-1:0]   arbIdx;
    logic               anyReq;
    logic               ownerHeld;

    assign anyReq    = |bus.req;
    // gnt is one-hot in OUTPUT, so this is req[sel] without a
    // variable-width index into req.
    assign ownerHeld = |(bus.req & bus.gnt);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
        .req   (bus.req),
        .ptr   (rrPtr),
        .grant (arbGnt),
        .index (arbIdx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_INPUT;
            bus.gnt          <= '0;
            bus.sel          <= '0;
            bus.inout_select <= 1'b0;
            bus.dir_req_out  <= 1'b0;
            rrPtr            <= '0;
        end else begin
            case (state)
                ST_INPUT: begin
                    // Neighbour flag high means it owns the channel.
                    if (anyReq && !bus.dir_req_in) begin
                        bus.dir_req_out <= 1'b1;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!anyReq) begin
                        bus.dir_req_out <= 1'b0;
                        state           <= ST_INPUT;
                    end else if (bus.dir_req_in) begin
                        // Both ends asked at once: the low-priority end
                        // backs off, the high-priority end keeps asking.
                        if (HIGH_PRIO == 0) begin
                            bus.dir_req_out <= 1'b0;
                            state           <= ST_INPUT;
                        end
                    end else begin
                        bus.gnt          <= arbGnt;
                        bus.sel          <= arbIdx;
                        bus.inout_select <= 1'b1;
                        rrPtr            <= rrNext(arbIdx, NUM_REQ);
                        state            <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (!ownerHeld) begin
                        bus.gnt          <= '0;
                        bus.inout_select <= 1'b0;
                        bus.dir_req_out  <= 1'b0;
                        state            <= ST_TURN;
                    end
                end
                default: begin
                    // One idle cycle for bus turnaround.
                    state <= ST_INPUT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bichannel_ctrl.sv
module tb_bichannel_ctrl;
    import bnoc_pkg::*;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    bichannel_ctrl_if #(.NUM_REQ(10)) if0 ();
    bichannel_ctrl_if #(.NUM_REQ(10)) ifH ();
    bichannel_ctrl_if #(.NUM_REQ(10)) ifL ();

    bichannel_ctrl #(.NUM_REQ(10), .HIGH_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    bichannel_ctrl #(.NUM_REQ(10), .HIGH_PRIO(1)) dutH (.clk(clk), .rst(rst), .bus(ifH));
    bichannel_ctrl #(.NUM_REQ(10), .HIGH_PRIO(0)) dutL (.clk(clk), .rst(rst), .bus(ifL));

    assign ifH.dir_req_in = ifL.dir_req_out;
    assign ifL.dir_req_in = ifH.dir_req_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.req = '0; if0.dir_req_in = 1'b0;
        ifH.req = '0; ifL.req = '0;
        tick();
        tick();
        nCompared++;
        if (if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL reset_gnt: got %h want 000", if0.gnt); end
        nCompared++;
        if (if0.sel !== 4'd0) begin nMismatched++; $display("FAIL reset_sel: got %0d want 0", if0.sel); end
        nCompared++;
        if (if0.inout_select !== 1'b0) begin nMismatched++; $display("FAIL reset_io: got %b want 0", if0.inout_select); end
        nCompared++;
        if (if0.dir_req_out !== 1'b0) begin nMismatched++; $display("FAIL reset_dro: got %b want 0", if0.dir_req_out); end
        nCompared++;
        if ({ifH.dir_req_out, ifL.dir_req_out} !== 2'b00) begin nMismatched++; $display("FAIL reset_pair_dro: got %b want 00", {ifH.dir_req_out, ifL.dir_req_out}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        if0.req = 10'h004; if0.dir_req_in = 1'b0;
        tick();
        nCompared++;
        if (if0.dir_req_out !== 1'b1) begin nMismatched++; $display("FAIL basic_dro_p1: got %b want 1", if0.dir_req_out); end
        nCompared++;
        if (if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL basic_gnt_p1: got %h want 000", if0.gnt); end
        tick();
        nCompared++;
        if (if0.gnt !== 10'h004) begin nMismatched++; $display("FAIL basic_gnt_p2: got %h want 004", if0.gnt); end
        nCompared++;
        if (if0.sel !== 4'd2) begin nMismatched++; $display("FAIL basic_sel_p2: got %0d want 2", if0.sel); end
        nCompared++;
        if (if0.inout_select !== 1'b1) begin nMismatched++; $display("FAIL basic_io_p2: got %b want 1", if0.inout_select); end
        if0.req = 10'h000;
        tick();
        nCompared++;
        if ({if0.gnt, if0.inout_select, if0.dir_req_out} !== 12'h000) begin nMismatched++; $display("FAIL basic_turn: got gnt=%h io=%b dro=%b want all 0", if0.gnt, if0.inout_select, if0.dir_req_out); end
        tick();
        nCompared++;
        if (if0.sel !== 4'd2) begin nMismatched++; $display("FAIL basic_sel_hold: got %0d want 2", if0.sel); end
    endtask

    task automatic test_round_robin();
        logic [9:0] expGnt [3];
        logic [3:0] expSel [3];
        expGnt[0] = 10'h001; expGnt[1] = 10'h200; expGnt[2] = 10'h001;
        expSel[0] = 4'd0;    expSel[1] = 4'd9;    expSel[2] = 4'd0;
        doReset();
        if0.req = 10'h201; if0.dir_req_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            nCompared++;
            if (if0.gnt !== 10'h000 || if0.dir_req_out !== 1'b1) begin nMismatched++; $display("FAIL rr_wait_%0d: got gnt=%h dro=%b want 000/1", k, if0.gnt, if0.dir_req_out); end
            tick();
            nCompared++;
            if (if0.gnt !== expGnt[k] || if0.sel !== expSel[k]) begin nMismatched++; $display("FAIL rr_grant_%0d: got gnt=%h sel=%0d want %h/%0d", k, if0.gnt, if0.sel, expGnt[k], expSel[k]); end
            if0.req = 10'h201 & ~expGnt[k];
            tick();
            nCompared++;
            if (if0.gnt !== 10'h000 || if0.inout_select !== 1'b0) begin nMismatched++; $display("FAIL rr_turn_%0d: got gnt=%h io=%b want 000/0", k, if0.gnt, if0.inout_select); end
            if0.req = 10'h201;
            tick();
            nCompared++;
            if (if0.dir_req_out !== 1'b0 || if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL rr_input_%0d: got dro=%b gnt=%h want 0/000", k, if0.dir_req_out, if0.gnt); end
        end
        if0.req = 10'h000;
        tick();
    endtask

    task automatic test_ignore_neighbour();
        doReset();
        if0.req = 10'h010; if0.dir_req_in = 1'b0;
        tick();
        tick();
        nCompared++;
        if (if0.gnt !== 10'h010 || if0.sel !== 4'd4) begin nMismatched++; $display("FAIL nb_grant: got gnt=%h sel=%0d want 010/4", if0.gnt, if0.sel); end
        if0.dir_req_in = 1'b1; if0.req = 10'h3FF;
        for (int k = 0; k < 3; k++) begin
            tick();
            nCompared++;
            if (if0.gnt !== 10'h010 || if0.inout_select !== 1'b1 || if0.dir_req_out !== 1'b1) begin nMismatched++; $display("FAIL nb_hold_%0d: got gnt=%h io=%b dro=%b want 010/1/1", k, if0.gnt, if0.inout_select, if0.dir_req_out); end
        end
        if0.req = 10'h3EF;
        tick();
        nCompared++;
        if (if0.gnt !== 10'h000 || if0.inout_select !== 1'b0 || if0.dir_req_out !== 1'b0) begin nMismatched++; $display("FAIL nb_turn: got gnt=%h io=%b dro=%b want 000/0/0", if0.gnt, if0.inout_select, if0.dir_req_out); end
        for (int k = 0; k < 3; k++) begin
            tick();
            nCompared++;
            if (if0.dir_req_out !== 1'b0 || if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL nb_blocked_%0d: got dro=%b gnt=%h want 0/000", k, if0.dir_req_out, if0.gnt); end
        end
        if0.dir_req_in = 1'b0; if0.req = 10'h000;
        tick();
    endtask

    task automatic test_wait_abort();
        if0.req = 10'h008; if0.dir_req_in = 1'b0;
        tick();
        nCompared++;
        if (if0.dir_req_out !== 1'b1) begin nMismatched++; $display("FAIL abort_dro_up: got %b want 1", if0.dir_req_out); end
        if0.req = 10'h000;
        tick();
        nCompared++;
        if (if0.dir_req_out !== 1'b0 || if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL abort_dro_down: got dro=%b gnt=%h want 0/000", if0.dir_req_out, if0.gnt); end
        tick();
        nCompared++;
        if (if0.gnt !== 10'h000 || if0.inout_select !== 1'b0) begin nMismatched++; $display("FAIL abort_idle: got gnt=%h io=%b want 000/0", if0.gnt, if0.inout_select); end
    endtask

    task automatic test_collision_low();
        if0.req = 10'h001; if0.dir_req_in = 1'b0;
        tick();
        if0.dir_req_in = 1'b1;
        tick();
        nCompared++;
        if (if0.dir_req_out !== 1'b0 || if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL lp_yield: got dro=%b gnt=%h want 0/000", if0.dir_req_out, if0.gnt); end
        tick();
        nCompared++;
        if (if0.dir_req_out !== 1'b0) begin nMismatched++; $display("FAIL lp_stay_input: got dro=%b want 0", if0.dir_req_out); end
        if0.dir_req_in = 1'b0; if0.req = 10'h000;
        tick();
    endtask

    task automatic test_async_reset();
        doReset();
        if0.req = 10'h020; if0.dir_req_in = 1'b0;
        tick();
        tick();
        nCompared++;
        if (if0.gnt !== 10'h020 || if0.sel !== 4'd5) begin nMismatched++; $display("FAIL ar_grant: got gnt=%h sel=%0d want 020/5", if0.gnt, if0.sel); end
        #2;
        rst = 1'b1;
        #1;
        nCompared++;
        if (if0.gnt !== 10'h000 || if0.inout_select !== 1'b0 || if0.dir_req_out !== 1'b0 || if0.sel !== 4'd0) begin nMismatched++; $display("FAIL ar_release: got gnt=%h io=%b dro=%b sel=%0d want 000/0/0/0", if0.gnt, if0.inout_select, if0.dir_req_out, if0.sel); end
        rst = 1'b0;
        tick();
        nCompared++;
        if (if0.dir_req_out !== 1'b1 || if0.gnt !== 10'h000) begin nMismatched++; $display("FAIL ar_rerequest: got dro=%b gnt=%h want 1/000", if0.dir_req_out, if0.gnt); end
        tick();
        nCompared++;
        if (if0.gnt !== 10'h020 || if0.sel !== 4'd5) begin nMismatched++; $display("FAIL ar_regrant: got gnt=%h sel=%0d want 020/5", if0.gnt, if0.sel); end
        if0.req = 10'h000;
        tick();
        tick();
    endtask

    task automatic test_pair();
        doReset();
        ifH.req = 10'h001; ifL.req = 10'h001;
        tick();
        nCompared++;
        if ({ifH.dir_req_out, ifL.dir_req_out} !== 2'b11) begin nMismatched++; $display("FAIL pair_both_req: got %b want 11", {ifH.dir_req_out, ifL.dir_req_out}); end
        tick();
        nCompared++;
        if ({ifH.dir_req_out, ifL.dir_req_out} !== 2'b10) begin nMismatched++; $display("FAIL pair_lp_yield: got %b want 10", {ifH.dir_req_out, ifL.dir_req_out}); end
        tick();
        nCompared++;
        if (ifH.gnt !== 10'h001 || ifH.inout_select !== 1'b1 || ifL.gnt !== 10'h000 || ifL.dir_req_out !== 1'b0) begin nMismatched++; $display("FAIL pair_hp_owns: got H gnt=%h io=%b L gnt=%h dro=%b want 001/1 000/0", ifH.gnt, ifH.inout_select, ifL.gnt, ifL.dir_req_out); end
        tick();
        ifH.req = 10'h000;
        tick();
        nCompared++;
        if (ifH.dir_req_out !== 1'b0 || ifH.inout_select !== 1'b0 || ifL.dir_req_out !== 1'b0) begin nMismatched++; $display("FAIL pair_hp_turn: got H dro=%b io=%b L dro=%b want 0/0/0", ifH.dir_req_out, ifH.inout_select, ifL.dir_req_out); end
        tick();
        nCompared++;
        if (ifL.dir_req_out !== 1'b1 || ifL.gnt !== 10'h000) begin nMismatched++; $display("FAIL pair_lp_req: got dro=%b gnt=%h want 1/000", ifL.dir_req_out, ifL.gnt); end
        tick();
        nCompared++;
        if (ifL.gnt !== 10'h001 || ifL.inout_select !== 1'b1 || ifH.inout_select !== 1'b0) begin nMismatched++; $display("FAIL pair_lp_grant: got L gnt=%h io=%b H io=%b want 001/1/0", ifL.gnt, ifL.inout_select, ifH.inout_select); end
        ifL.req = 10'h000;
        tick();
        tick();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_ignore_neighbour();
        test_wait_abort();
        test_collision_low();
        test_async_reset();
        test_pair();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bichannel_ctrl.md
BICHANNEL_CTRL -- requirements
Module: bichannel_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 10, number of local requesters (input ports) competing for this channel.
REQ-002 SHALL have parameter HIGH_PRIO, default 0, 1 = this end wins simultaneous direction requests, 0 = this end yields.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  in  NUM_REQ  per-input-port channel request (one bit of each port's channel_req).
REQ-006 SHALL have port gnt  out  NUM_REQ  one-hot channel grant back to the ports (feeds channel_gnt).
REQ-007 SHALL have port sel  out  4  binary index of granted requester, drives the output mux select.
REQ-008 SHALL have port inout_select  out  1  1 = this end drives the bidirectional channel, 0 = this end receives.
REQ-009 SHALL have port dir_req_out  out  1  direction request/ownership flag to the neighbour's dir_req_in.
REQ-010 SHALL have port dir_req_in  in  1  neighbour's dir_req_out.

Function
REQ-011 SHALL implement FSM states INPUT, WAIT, OUTPUT, TURN; all outputs registered.
REQ-012 INPUT: inout_select=0, gnt=0, dir_req_out=0; when |req=1 and dir_req_in=0 SHALL assert dir_req_out and go WAIT next cycle.
REQ-013 INPUT with dir_req_in=1 SHALL stay INPUT regardless of req (neighbour owns channel).
REQ-014 WAIT, dir_req_in=0, |req=1: next cycle OUTPUT with inout_select=1, gnt one-hot and sel = round-robin winner of req sampled at that edge.
REQ-015 WAIT, dir_req_in=1 (collision): HIGH_PRIO=1 stays WAIT holding dir_req_out=1; HIGH_PRIO=0 drops dir_req_out and returns to INPUT next cycle.
REQ-016 WAIT with req=0 SHALL drop dir_req_out and return to INPUT next cycle.
REQ-017 OUTPUT: gnt, sel, inout_select=1, dir_req_out=1 held while req[sel]=1; dir_req_in and other requests ignored.
REQ-018 OUTPUT with req[sel]=0: next cycle TURN with gnt=0, inout_select=0, dir_req_out=0.
REQ-019 TURN SHALL last exactly one cycle then go INPUT; no grant or drive in TURN (bus turnaround).
REQ-020 Round robin: pointer = last granted index + 1 modulo NUM_REQ, updated on entry to OUTPUT; search starts at pointer, wraps at NUM_REQ-1 -> 0.
REQ-021 Latency |req rising (dir_req_in=0, in INPUT) -> gnt asserted = 2 cycles.
REQ-022 gnt SHALL never have more than one bit set; inout_select=1 only in OUTPUT.
REQ-023 sel SHALL keep its last value outside OUTPUT.

Reset
REQ-024 rst=1 SHALL asynchronously force state INPUT, gnt=0, sel=0, inout_select=0, dir_req_out=0, rr pointer=0.
REQ-025 Reset asserted in OUTPUT SHALL release the channel immediately with no TURN cycle; first post-reset request behaves per REQ-012.

Structure
REQ-026 State enum, NUM_REQ default and SEL_W=4 SHALL live in shared package bnoc_pkg.
REQ-027 Round-robin search SHALL be one sub-module rr_arbiter (req, pointer in; one-hot grant, index out), combinational.

Verification
REQ-028 req=0x004, dir_req_in=0 -> dir_req_out=1 at +1, gnt=0x004, sel=2, inout_select=1 at +2.
REQ-029 req=0x201 held; each requester drops after grant and re-raises -> grants alternate 0x001, 0x200, 0x001, TURN cycle between each.
REQ-030 Two instances cross-wired, HIGH_PRIO 1/0, both req=0x001 same cycle -> HP reaches OUTPUT, LP back to INPUT, LP granted only after HP TURN.
REQ-031 In OUTPUT with gnt=0x010, raise dir_req_in=1 and req=0x3FF -> gnt stays 0x010 until req[4]=0, then TURN, then INPUT with no new dir_req_out while dir_req_in=1.
REQ-032 rst pulsed mid-OUTPUT -> gnt=0, inout_select=0, dir_req_out=0 same cycle, sel=0.
REQ-033 req=0x008 rises then drops during WAIT -> dir_req_out falls next cycle, gnt never asserted.
